// File: rtl/sqrt_bf16_vec.sv
// sqrt_bf16_vec: LANES-wide bfloat16/FP16 square root, one root bit per cycle per lane.
// Define SQRT_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module sqrt_bf16_vec #(
  parameter int LANES = 4,
  parameter int EXP_W = 8,
  parameter int FRAC_W = 7,
  localparam int W = 1 + EXP_W + FRAC_W
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               valid_in,
  output logic               ready_in,
  input  logic [LANES*W-1:0] operand,
  input  logic [LANES-1:0]   lane_en,
  input  logic               flush,
  output logic               valid_out,
  input  logic               ready_out,
  output logic [LANES*W-1:0] result,
  output logic [LANES-1:0]   invalid
);
  localparam int N = FRAC_W + 2;
  localparam int XW = 2 * N;
  localparam int RW = N + 2;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N);
  localparam logic [EXP_W:0] BIAS = (EXP_W+1)'((1 << (EXP_W - 1)) - 1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic accept, step, pack;
  assign ready_in = !flush && (state == IDLE || (state == DONE && ready_out));
  assign accept = valid_in && ready_in;
  assign valid_out = state == DONE && !flush;
  assign step = state == CALC && !flush && cnt != LAST;
  assign pack = state == CALC && !flush && cnt == LAST;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    state_nx = flush ? IDLE
             : accept ? CALC
             : pack ? DONE
             : (state == DONE && ready_out) ? IDLE
             : (state inside {IDLE, CALC, DONE}) ? state
             : IDLE;
  end
  // Counter runs N recurrence steps, then one packing cycle before DONE.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) cnt <= '0;
    else cnt <= step ? cnt + 1'b1 : '0;
  end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [W-1:0] op, sres_d, sres, packed_w, res;
    logic sgn, spec_d, inv_d, spec, inv, en, inv_o, ge;
    logic [EXP_W-1:0] ex, rexp_w, rexp;
    logic [FRAC_W-1:0] fr;
    logic signed [EXP_W:0] e, e_half;
    logic [XW-1:0] x_d, x;
    logic [RW-1:0] rem;
    logic [RW+1:0] rem_sh, trial;
    logic [N-1:0] q;
    assign op = operand[i*W +: W];
    assign {sgn, ex, fr} = op;
    assign e = $signed({1'b0, ex} - BIAS);
    assign e_half = e >>> 1;
    assign rexp_w = EXP_W'(e_half + BIAS);
    // Odd exponents fold one factor of two into the radicand so the root exponent halves exactly.
    assign x_d = e[0] ? XW'({1'b1, fr}) << (N + 1) : XW'({1'b1, fr}) << N;
    assign spec_d = ex == '0 || &ex || sgn;
    assign sres_d = ex == '0 ? {sgn, {(W-1){1'b0}}}
                  : (&ex && fr == '0 && !sgn) ? op
                  : QNAN;
    assign inv_d = ex != '0 && (&ex ? (fr != '0 ? !fr[FRAC_W-1] : sgn) : sgn);
    assign rem_sh = {rem, x[XW-1 -: 2]};
    assign trial = {2'b00, q, 2'b01};
    assign ge = rem_sh >= trial;
`ifdef SQRT_RNE_EN
    logic inc;
    logic [FRAC_W:0] fsum;
    assign inc = q[0] && (rem != '0 || q[1]);
    assign fsum = {1'b0, q[FRAC_W:1]} + (FRAC_W+1)'(inc);
    assign packed_w = {1'b0, rexp + EXP_W'(fsum[FRAC_W]), fsum[FRAC_W-1:0]};
`else
    assign packed_w = {1'b0, rexp, q[FRAC_W:1]};
`endif
    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        x <= '0;
        rem <= '0;
        q <= '0;
        spec <= 1'b0;
        inv <= 1'b0;
        en <= 1'b0;
        sres <= '0;
        rexp <= '0;
        res <= '0;
        inv_o <= 1'b0;
      end else if (accept) begin
        x <= x_d;
        rem <= '0;
        q <= '0;
        spec <= spec_d;
        inv <= inv_d;
        en <= lane_en[i];
        sres <= sres_d;
        rexp <= rexp_w;
      end else if (step) begin
        x <= x << 2;
        rem <= RW'(ge ? rem_sh - trial : rem_sh);
        q <= {q[N-2:0], ge};
      end else if (pack) begin
        res <= !en ? '0 : spec ? sres : packed_w;
        inv_o <= en && spec && inv;
      end
    end
    assign result[i*W +: W] = res;
    assign invalid[i] = inv_o;
  end
endmodule

// File: tb/tb_sqrt_bf16_vec.sv
// tb_sqrt_bf16_vec: scoreboard bench for sqrt_bf16_vec at default parameters (4 lanes, bfloat16).
module tb_sqrt_bf16_vec;
  logic CLK = 0, nRST = 0, valid_in = 0, flush = 0, ready_out = 1;
  logic ready_in, valid_out;
  logic [63:0] operand = '0, result;
  logic [3:0] lane_en = '0, invalid;
  int n_chk = 0, n_pass = 0;
  typedef struct packed {logic [63:0] r; logic [3:0] v;} exp_t;
  exp_t sb[$];
`ifdef SQRT_RNE_EN
  localparam logic [15:0] RND3 = 16'h3FDE;
`else
  localparam logic [15:0] RND3 = 16'h3FDD;
`endif
  always #5 CLK = ~CLK;
  sqrt_bf16_vec dut (.CLK(CLK), .nRST(nRST), .valid_in(valid_in), .ready_in(ready_in),
    .operand(operand), .lane_en(lane_en), .flush(flush), .valid_out(valid_out),
    .ready_out(ready_out), .result(result), .invalid(invalid));
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  // Reference: integer square root of the scaled significand by exhaustive search.
  function automatic logic [16:0] model(input logic [15:0] op);
    logic [7:0] ex;
    logic [6:0] fr;
    int e, re, f;
    longint m, x, q, rem;
    ex = op[14:7];
    fr = op[6:0];
    if (ex == 8'd0) return {1'b0, op[15], 15'd0};
    if (ex == 8'hFF) begin
      if (fr == 7'd0 && !op[15]) return {1'b0, op};
      return {(fr == 7'd0) || !fr[6], 16'h7FC0};
    end
    if (op[15]) return {1'b1, 16'h7FC0};
    e = int'(ex) - 127;
    m = 128 + longint'(fr);
    x = (e % 2 != 0) ? m << 10 : m << 9;
    q = 0;
    while ((q + 1) * (q + 1) <= x) q++;
    rem = x - q * q;
    f = int'(q >> 1) & 127;
    re = (e >>> 1) + 127;
`ifdef SQRT_RNE_EN
    if ((q & 1) != 0 && (rem != 0 || (q & 2) != 0)) begin
      f++;
      if (f == 128) begin f = 0; re++; end
    end
`endif
    return {1'b0, 1'b0, 8'(re), 7'(f)};
  endfunction
  function automatic exp_t expect_vec(input logic [63:0] ops, input logic [3:0] en);
    exp_t t;
    logic [16:0] m;
    t = '0;
    for (int i = 0; i < 4; i++) begin
      m = model(ops[i*16 +: 16]);
      if (en[i]) begin t.r[i*16 +: 16] = m[15:0]; t.v[i] = m[16]; end
    end
    return t;
  endfunction
  task automatic drive_op(input logic [63:0] ops, input logic [3:0] en, input exp_t ex);
    @(negedge CLK);
    operand = ops; lane_en = en; valid_in = 1;
    sb.push_back(ex);
    @(posedge CLK); #1 valid_in = 0;
  endtask
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!valid_out && lat < 40) begin @(posedge CLK); #1; lat++; end
  endtask
  task automatic test_reset;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    n_chk++; if (valid_out !== 1'b0) $display("FAIL reset valid_out got %b want 0", valid_out); else n_pass++;
    n_chk++; if (result !== 64'h0) $display("FAIL reset result got %h want 0", result); else n_pass++;
    n_chk++; if (invalid !== 4'h0) $display("FAIL reset invalid got %b want 0", invalid); else n_pass++;
    nRST = 1; #1;
    n_chk++; if (ready_in !== 1'b1) $display("FAIL reset ready_in got %b want 1", ready_in); else n_pass++;
  endtask
  task automatic test_vector(input string nm, input logic [63:0] ops, input logic [3:0] en, input exp_t ex);
    exp_t e;
    int lat;
    drive_op(ops, en, ex);
    wait_valid(lat);
    e = sb.pop_front();
    n_chk++; if (lat !== 10) $display("FAIL %s latency got %0d want 10", nm, lat); else n_pass++;
    n_chk++; if (result !== e.r) $display("FAIL %s result got %h want %h", nm, result, e.r); else n_pass++;
    n_chk++; if (invalid !== e.v) $display("FAIL %s invalid got %b want %b", nm, invalid, e.v); else n_pass++;
    @(posedge CLK); #1;
    n_chk++; if (valid_out !== 1'b0) $display("FAIL %s consumed valid_out got %b want 0", nm, valid_out); else n_pass++;
  endtask
  task automatic test_back_to_back;
    exp_t a, b;
    int lat;
    logic [63:0] ops_b = 64'h3E00_4200_40A0_3C80;
    drive_op(64'h4110_4080_3F80_4110, 4'hF, '{r: 64'h4040_4000_3F80_4040, v: 4'h0});
    ready_out = 0;
    wait_valid(lat);
    a = sb.pop_front();
    n_chk++; if (lat !== 10) $display("FAIL b2b first latency got %0d want 10", lat); else n_pass++;
    operand = 64'hDEAD_BEEF_1234_5678; lane_en = 4'hF; valid_in = 1;
    for (int k = 0; k < 5; k++) begin
      n_chk++; if (valid_out !== 1'b1) $display("FAIL b2b stall%0d valid_out got %b want 1", k, valid_out); else n_pass++;
      n_chk++; if (result !== a.r) $display("FAIL b2b stall%0d result got %h want %h", k, result, a.r); else n_pass++;
      n_chk++; if (ready_in !== 1'b0) $display("FAIL b2b stall%0d ready_in got %b want 0", k, ready_in); else n_pass++;
      @(posedge CLK); #1;
    end
    operand = ops_b; ready_out = 1;
    sb.push_back(expect_vec(ops_b, 4'hF));
    #1;
    n_chk++; if (ready_in !== 1'b1) $display("FAIL b2b release ready_in got %b want 1", ready_in); else n_pass++;
    @(posedge CLK); #1 valid_in = 0;
    wait_valid(lat);
    b = sb.pop_front();
    n_chk++; if (lat !== 10) $display("FAIL b2b second latency got %0d want 10", lat); else n_pass++;
    n_chk++; if (result !== b.r) $display("FAIL b2b second result got %h want %h", result, b.r); else n_pass++;
    lat = 0;
    repeat (14) begin @(posedge CLK); #1; if (valid_out) lat++; end
    n_chk++; if (lat !== 0) $display("FAIL b2b ghost valid cycles got %0d want 0", lat); else n_pass++;
  endtask
  task automatic test_flush;
    exp_t e;
    int lat;
    logic [63:0] ops = 64'h4080_4080_4080_4080;
    drive_op(ops, 4'hF, expect_vec(ops, 4'hF));
    void'(sb.pop_back());
    repeat (3) begin @(posedge CLK); #1; end
    flush = 1; valid_in = 1; #1;
    n_chk++; if (ready_in !== 1'b0) $display("FAIL flush ready_in got %b want 0", ready_in); else n_pass++;
    @(posedge CLK); #1 flush = 0; valid_in = 0; #1;
    n_chk++; if (valid_out !== 1'b0) $display("FAIL flush valid_out got %b want 0", valid_out); else n_pass++;
    n_chk++; if (ready_in !== 1'b1) $display("FAIL flush idle ready_in got %b want 1", ready_in); else n_pass++;
    lat = 0;
    repeat (15) begin @(posedge CLK); #1; if (valid_out) lat++; end
    n_chk++; if (lat !== 0) $display("FAIL flush dropped valid cycles got %0d want 0", lat); else n_pass++;
    ops = 64'h4300_3F00_4110_40C0;
    drive_op(ops, 4'hF, expect_vec(ops, 4'hF));
    wait_valid(lat);
    e = sb.pop_front();
    n_chk++; if (lat !== 10) $display("FAIL flush recover latency got %0d want 10", lat); else n_pass++;
    n_chk++; if (result !== e.r) $display("FAIL flush recover result got %h want %h", result, e.r); else n_pass++;
    @(posedge CLK); #1;
  endtask
  task automatic test_reset_mid_done;
    exp_t e;
    int lat;
    logic [63:0] ops = 64'h4000_4080_4110_3F80;
    drive_op(ops, 4'hF, expect_vec(ops, 4'hF));
    ready_out = 0;
    wait_valid(lat);
    e = sb.pop_front();
    n_chk++; if (result !== e.r) $display("FAIL rstdone pre result got %h want %h", result, e.r); else n_pass++;
    @(posedge CLK); #3 nRST = 0; #1;
    n_chk++; if (valid_out !== 1'b0) $display("FAIL rstdone valid_out got %b want 0", valid_out); else n_pass++;
    n_chk++; if (result !== 64'h0) $display("FAIL rstdone result got %h want 0", result); else n_pass++;
    n_chk++; if (invalid !== 4'h0) $display("FAIL rstdone invalid got %b want 0", invalid); else n_pass++;
    @(negedge CLK); nRST = 1; #1;
    n_chk++; if (ready_in !== 1'b1) $display("FAIL rstdone ready_in got %b want 1", ready_in); else n_pass++;
    ready_out = 1;
    lat = 0;
    repeat (15) begin @(posedge CLK); #1; if (valid_out) lat++; end
    n_chk++; if (lat !== 0) $display("FAIL rstdone spurious valid cycles got %0d want 0", lat); else n_pass++;
  endtask
  task automatic test_random;
    exp_t e;
    int lat;
    logic [63:0] ops;
    logic [3:0] en;
    for (int n = 0; n < 8; n++) begin
      ops = {$urandom, $urandom};
      if (n % 2 == 0) ops = ops & 64'h7FFF_7FFF_7FFF_7FFF;
      en = 4'($urandom_range(1, 15));
      drive_op(ops, en, expect_vec(ops, en));
      wait_valid(lat);
      e = sb.pop_front();
      n_chk++; if (lat !== 10) $display("FAIL rand%0d latency got %0d want 10", n, lat); else n_pass++;
      n_chk++; if (result !== e.r) $display("FAIL rand%0d ops %h result got %h want %h", n, ops, result, e.r); else n_pass++;
      n_chk++; if (invalid !== e.v) $display("FAIL rand%0d invalid got %b want %b", n, invalid, e.v); else n_pass++;
      @(posedge CLK); #1;
    end
  endtask
  initial begin
    test_reset();
    test_vector("basic", 64'h3F80_4000_4110_4080, 4'hF, '{r: 64'h3F80_3FB5_4040_4000, v: 4'h0});
    test_vector("round3", {4{16'h4040}}, 4'hF, '{r: {4{RND3}}, v: 4'h0});
    test_vector("specials", 64'h7F81_7F80_8000_C080, 4'hF, '{r: 64'h7FC0_7F80_8000_7FC0, v: 4'b1001});
    test_vector("lane_en", {4{16'h4080}}, 4'b0101, '{r: 64'h0000_4000_0000_4000, v: 4'h0});
    test_vector("lane_en_inv", {4{16'hC080}}, 4'b0101, '{r: 64'h0000_7FC0_0000_7FC0, v: 4'b0101});
    test_back_to_back();
    test_flush();
    test_reset_mid_done();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sqrt_bf16_vec.md
SQRT_BF16_VEC -- requirements
Module: sqrt_bf16_vec

Interface
REQ-001 SHALL have parameter LANES, default 4, number of independent parallel lanes.
REQ-002 SHALL have parameter EXP_W, default 8, exponent width (5 gives FP16).
REQ-003 SHALL have parameter FRAC_W, default 7, fraction width (10 gives FP16); W = 1+EXP_W+FRAC_W.
REQ-004 SHALL have ports CLK in 1 clock; nRST in 1 reset; one clock only; reset is asynchronous and active-low.
REQ-005 SHALL have ports valid_in in 1 request; ready_in out 1 can accept; operand in LANES*W packed, lane i at [i*W +: W]; lane_en in LANES lane enable.
REQ-006 SHALL have ports flush in 1 synchronous abort; valid_out out 1 result valid; ready_out in 1 downstream ready; result out LANES*W; invalid out LANES IEEE invalid flag.

Function
REQ-007 SHALL implement FSM IDLE -> CALC -> DONE; accept on valid_in & ready_in; ready_in = !flush & (IDLE | (DONE & ready_out)).
REQ-008 SHALL capture operand and lane_en on the accept edge, then spend exactly FRAC_W+2 cycles in CALC; valid_out is first high FRAC_W+3 cycles after the accept edge, for all lanes and specials alike.
REQ-009 SHALL, per lane, decode e = exp - bias (signed EXP_W+1 bits), M = {1,frac}; radicand X = M << (FRAC_W+2) if e even, M << (FRAC_W+3) if e odd, width 2*FRAC_W+4.
REQ-010 SHALL produce root Q of FRAC_W+2 bits by restoring digit recurrence, one bit per CALC cycle, all lanes in lockstep on one shared counter.
REQ-011 SHALL set result exponent = (e >>> 1) + bias, fraction = Q[FRAC_W:1], round bit = Q[0], sticky = (final remainder != 0).
REQ-012 SHALL treat specials: +0 gives +0; -0 gives -0; subnormal flushes to a signed zero of the input sign; +inf gives +inf; -inf, negative normal, and NaN give qNaN {0, all-ones exp, 1, zeros}.
REQ-013 SHALL set invalid[i]=1 for negative nonzero non-NaN inputs and for sNaN (frac MSB 0, frac != 0); 0 otherwise.
REQ-014 SHALL drive result lane = 0 and invalid = 0 for lanes with lane_en=0.
REQ-015 SHALL hold valid_out, result, invalid stable in DONE while ready_out=0; leave DONE on ready_out=1 (to CALC if a new accept coincides, else IDLE).
REQ-016 SHALL, on flush=1 in any state, go to IDLE next cycle, drop the operation, and drive valid_out=0; flush wins over simultaneous valid_in.
REQ-017 SHALL ignore valid_in while ready_in=0; no operand is queued.

Reset
REQ-018 SHALL, on nRST low, immediately force state IDLE, counter 0, valid_out 0, result 0, invalid 0; ready_in is 1 after release.
REQ-019 SHALL discard an in-flight operation on reset mid-CALC or mid-DONE with no spurious valid_out afterward.

Configuration
REQ-020 SHALL honour macro SQRT_RNE_EN: defined gives round-to-nearest-even, incrementing when round & (sticky | fraction LSB).
REQ-021 SHALL, with SQRT_RNE_EN defined, on fraction overflow from rounding, increment the exponent and set fraction 0.
REQ-022 SHALL, with SQRT_RNE_EN undefined, truncate: round and sticky are ignored and no increment logic is present.
REQ-023 SHALL keep latency and interface identical with or without SQRT_RNE_EN.

Verification
REQ-024 SHALL cover, default params: lanes {0x4080,0x4110,0x4000,0x3F80}, lane_en=0xF -> {0x4000,0x4040,0x3FB5,0x3F80}; valid_out at cycle 10 after accept; invalid=0.
REQ-025 SHALL cover: operand 0x4040 (3.0) -> 0x3FDE with SQRT_RNE_EN, 0x3FDD without.
REQ-026 SHALL cover specials: {0xC080,0x8000,0x7F80,0x7F81} -> {0x7FC0,0x8000,0x7F80,0x7FC0}; invalid=0b1001 (lane 0 LSB).
REQ-027 SHALL cover: ready_out low 5 cycles after valid_out -> result stable, ready_in=0; ready_out=1 with a new valid_in in the same cycle -> accepted, next valid_out 10 cycles later.
REQ-028 SHALL cover: flush at CALC cycle 4 -> IDLE next cycle, no valid_out for that op; nRST pulse mid-DONE -> all outputs 0, ready_in=1 after release.
REQ-029 SHALL cover: lane_en=0b0101 with all operands 0x4080 -> result lanes {0x4000,0,0x4000,0}.
